// File: rtl/boot_pkg.sv
// Shared constants, ALU function table and FSM state type for the instruction-memory boot loader.
package boot_pkg;

  localparam logic [6:0]  OPC_OPIMM = 7'h13;
  localparam logic [6:0]  OPC_OP    = 7'h33;
  localparam logic [31:0] JAL_SELF  = 32'h0000_006F;

  // Word index width: covers up to N_OPS+2 = 6 words plus the verify compare tail.
  localparam int unsigned IdxW = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StVerify,
    StDone,
    StFail
  } boot_state_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
  } alu_fn_t;

  function automatic alu_fn_t alu_fn(input logic [2:0] op);
    alu_fn_t fn;
    unique case (op)
      3'b000: fn = '{funct7: 7'h00, funct3: 3'd0};
      3'b001: fn = '{funct7: 7'h20, funct3: 3'd0};
      3'b010: fn = '{funct7: 7'h00, funct3: 3'd7};
      3'b011: fn = '{funct7: 7'h00, funct3: 3'd6};
      3'b100: fn = '{funct7: 7'h00, funct3: 3'd4};
      3'b101: fn = '{funct7: 7'h00, funct3: 3'd1};
      3'b110: fn = '{funct7: 7'h00, funct3: 3'd5};
      3'b111: fn = '{funct7: 7'h00, funct3: 3'd2};
      default: fn = '{funct7: 7'h00, funct3: 3'd0};
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/rv_instr_encoder.sv
// Combinational generator of the boot program word at a given index:
// N_OPS addi loads, one R-type ALU op, then a jal-to-self.
module rv_instr_encoder
  import boot_pkg::*;
#(
  parameter int unsigned N_OPS = 2,
  parameter int unsigned OP_W  = 8
) (
  input  logic [IdxW-1:0]       idx_i,
  input  logic [N_OPS*OP_W-1:0] ops_i,
  input  logic [2:0]            alu_op_i,
  output logic [31:0]           instr_o
);

  alu_fn_t     fn;
  logic [11:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs2;

  assign fn  = alu_fn(alu_op_i);
  assign rd  = {2'b00, idx_i} + 5'd1;
  assign rs2 = (N_OPS == 1) ? 5'd1 : 5'd2;

  always_comb begin
    imm = '0;
    for (int k = 0; k < N_OPS; k++) begin
      if (32'(idx_i) == k) imm[OP_W-1:0] = ops_i[k*OP_W +: OP_W];
    end
  end

  always_comb begin
    if (32'(idx_i) < N_OPS) begin
      instr_o = {imm, 5'd0, 3'b000, rd, OPC_OPIMM};
    end else if (32'(idx_i) == N_OPS) begin
      instr_o = {fn.funct7, rs2, 5'd1, fn.funct3, rd, OPC_OP};
    end else begin
      instr_o = JAL_SELF;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Writes a generated RV32I boot program into imem over a valid/ready port, then releases the CPU.
// Define IMEM_READBACK_VERIFY_EN to read back and compare each pass, with bounded reloads.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned N_OPS      = 2,
  parameter int unsigned OP_W       = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [N_OPS*OP_W-1:0] ops_i,
  input  logic [2:0]            alu_op_i,
  input  logic                  imem_ready_i,
  output logic                  imem_we_o,
  output logic [31:0]           imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cpu_hold_o,
  output logic [31:0]           imem_raddr_o,
  input  logic [31:0]           imem_rdata_i,
  output logic                  verify_err_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_OPS + 1);

  boot_state_e           state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [N_OPS*OP_W-1:0] ops_q, ops_d;
  logic [2:0]            alu_q, alu_d;
  logic                  auto_q, auto_d;
  logic [IdxW-1:0]       enc_idx;
  logic [31:0]           enc_word;
  logic [31:0]           idx_offset;
  logic                  accept;

  rv_instr_encoder #(
    .N_OPS (N_OPS),
    .OP_W  (OP_W)
  ) u_enc (
    .idx_i    (enc_idx),
    .ops_i    (ops_q),
    .alu_op_i (alu_q),
    .instr_o  (enc_word)
  );

  assign accept = (start_i && (state_q == StIdle || state_q == StDone)) ||
                  (state_q == StIdle && auto_q);
  assign idx_offset = {{(32 - IdxW - 2){1'b0}}, idx_q, 2'b00};

`ifdef IMEM_READBACK_VERIFY_EN
  localparam logic [IdxW-1:0] VerEnd = IdxW'(N_OPS + 2);

  logic [7:0] retry_q, retry_d;
  logic       mm_q, mm_d;
  logic       cur_mm;

  // Read data lags the read address by one cycle, so compare against the previous index.
  assign enc_idx = (state_q == StVerify) ? idx_q - IdxW'(1) : idx_q;
  assign cur_mm  = (idx_q != '0) && (imem_rdata_i != enc_word);
  assign imem_raddr_o = BASE_ADDR + idx_offset;
  assign verify_err_o = (state_q == StFail);
`else
  logic unused_readback;

  assign enc_idx = idx_q;
  assign unused_readback = ^{imem_rdata_i, 32'(MAX_RETRY)};
  assign imem_raddr_o = BASE_ADDR;
  assign verify_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ops_q   <= '0;
      alu_q   <= '0;
      auto_q  <= AUTO_START;
`ifdef IMEM_READBACK_VERIFY_EN
      retry_q <= '0;
      mm_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ops_q   <= ops_d;
      alu_q   <= alu_d;
      auto_q  <= auto_d;
`ifdef IMEM_READBACK_VERIFY_EN
      retry_q <= retry_d;
      mm_q    <= mm_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ops_d   = ops_q;
    alu_d   = alu_q;
    auto_d  = auto_q;
`ifdef IMEM_READBACK_VERIFY_EN
    retry_d = retry_q;
    mm_d    = mm_q;
`endif
    if (accept) begin
      state_d = StLoad;
      idx_d   = '0;
      ops_d   = ops_i;
      alu_d   = alu_op_i;
      auto_d  = 1'b0;
`ifdef IMEM_READBACK_VERIFY_EN
      retry_d = '0;
`endif
    end else begin
      unique case (state_q)
        StLoad: begin
          if (imem_ready_i) begin
            if (idx_q == LastIdx) begin
              idx_d = '0;
`ifdef IMEM_READBACK_VERIFY_EN
              state_d = StVerify;
              mm_d    = 1'b0;
`else
              state_d = StDone;
`endif
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
`ifdef IMEM_READBACK_VERIFY_EN
        StVerify: begin
          if (idx_q == VerEnd) begin
            idx_d = '0;
            if (mm_q || cur_mm) begin
              if (32'(retry_q) < MAX_RETRY) begin
                retry_d = retry_q + 8'd1;
                state_d = StLoad;
              end else begin
                state_d = StFail;
              end
            end else begin
              state_d = StDone;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
            mm_d  = mm_q || cur_mm;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign imem_we_o    = (state_q == StLoad);
  assign imem_addr_o  = BASE_ADDR + idx_offset;
  assign imem_wdata_o = imem_we_o ? enc_word : 32'h0;
  assign busy_o       = (state_q == StLoad) || (state_q == StVerify);
  assign done_o       = (state_q == StDone);
  assign cpu_hold_o   = ~done_o;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (default parameters, N_OPS=2, OP_W=8).
module tb_imem_boot_loader;

  localparam logic [31:0] JAL = 32'h0000_006F;
`ifdef IMEM_READBACK_VERIFY_EN
  localparam int VX = 5;
`else
  localparam int VX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ops = 16'h0;
  logic [2:0]  alu_op = 3'b000;
  logic        ready = 1'b1;
  logic        we, busy, done, cpu_hold, verify_err;
  logic [31:0] addr, wdata, raddr, rdata;
  logic        bad = 1'b0;
  logic [31:0] mem [8];

  int          tests = 0;
  int          fails = 0;
  logic [31:0] wa [16];
  logic [31:0] wd [16];
  int          nw;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .ops_i        (ops),
    .alu_op_i     (alu_op),
    .imem_ready_i (ready),
    .imem_we_o    (we),
    .imem_addr_o  (addr),
    .imem_wdata_o (wdata),
    .busy_o       (busy),
    .done_o       (done),
    .cpu_hold_o   (cpu_hold),
    .imem_raddr_o (raddr),
    .imem_rdata_i (rdata),
    .verify_err_o (verify_err)
  );

  // Simple imem with one-cycle read latency; 'bad' corrupts the readback of word 1.
  always @(posedge clk) begin
    if (we && ready) mem[addr[4:2]] <= wdata;
    rdata <= (bad && raddr == 32'd4) ? 32'h0 : mem[raddr[4:2]];
  end

  // Runs one load from the current negedge until done, logging accepted writes.
  task automatic run_load(input int budget, input logic [31:0] stall_addr, input int stall_n,
                          input logic [31:0] stall_word, input int pulse_at,
                          output int cyc_done);
    int cyc = 0;
    int left = stall_n;
    cyc_done = -1;
    nw = 0;
    while (cyc < budget && cyc_done < 0) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 1) begin
        tests++;
        if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1) begin
          fails++;
          $display("FAIL first_cycle: done=%b cpu_hold=%b busy=%b, need 0 1 1",
                   done, cpu_hold, busy);
        end
      end
      if (cyc == pulse_at) begin
        start = 1'b1;
        ops = 16'hEEEE;
        alu_op = 3'b111;
      end
      if (done === 1'b1) begin
        cyc_done = cyc;
      end else if (we === 1'b1 && addr === stall_addr && left > 0) begin
        ready = 1'b0;
        left--;
        tests++;
        if (wdata !== stall_word) begin
          fails++;
          $display("FAIL stall_hold: wdata=%h, need %h", wdata, stall_word);
        end
      end else begin
        ready = 1'b1;
        if (we === 1'b1 && nw < 16) begin
          wa[nw] = addr;
          wd[nw] = wdata;
          nw++;
        end
      end
    end
    ready = 1'b1;
    if (cyc_done < 0) begin
      tests++;
      fails++;
      $display("FAIL load_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic check_words(input string name, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ew [4];
    ew = '{e0, e1, e2, e3};
    tests++;
    if (nw !== 4) begin
      fails++;
      $display("FAIL %s_count: writes=%0d, need 4", name, nw);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (wa[k] !== 32'(4 * k) || wd[k] !== ew[k]) begin
        fails++;
        $display("FAIL %s_word%0d: got %h@%h, need %h@%h", name, k, wd[k], wa[k], ew[k], 4 * k);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    ops = {8'd5, 8'd10};
    alu_op = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (we !== 1'b0 || addr !== 32'h0 || wdata !== 32'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_port: we=%b addr=%h wdata=%h busy=%b, need 0 0 0 0",
               we, addr, wdata, busy);
    end
    tests++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || verify_err !== 1'b0 || raddr !== 32'h0) begin
      fails++;
      $display("FAIL reset_ctrl: done=%b hold=%b verr=%b raddr=%h, need 0 1 0 0",
               done, cpu_hold, verify_err, raddr);
    end
    rst = 1'b0;
  endtask

  task automatic test_auto_load();
    int d;
    run_load(60, 32'hFFFF_FFFF, 0, 32'h0, -1, d);
    tests++;
    if (d !== 5 + VX) begin
      fails++;
      $display("FAIL auto_latency: done at %0d, need %0d", d, 5 + VX);
    end
    check_words("auto", 32'h00A00093, 32'h00500113, 32'h002081B3, JAL);
    tests++;
    if (cpu_hold !== 1'b0 || we !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL auto_release: hold=%b we=%b busy=%b, need 0 0 0", cpu_hold, we, busy);
    end
  endtask

  task automatic test_sub_stall();
    int d;
    ops = {8'd5, 8'd10};
    alu_op = 3'b001;
    start = 1'b1;
    run_load(60, 32'd4, 3, 32'h00500113, -1, d);
    tests++;
    if (d !== 8 + VX) begin
      fails++;
      $display("FAIL stall_latency: done at %0d, need %0d", d, 8 + VX);
    end
    check_words("sub", 32'h00A00093, 32'h00500113, 32'h402081B3, JAL);
  endtask

  task automatic test_back_to_back();
    int d;
    ops = {8'd1, 8'd2};
    alu_op = 3'b100;
    start = 1'b1;
    run_load(60, 32'hFFFF_FFFF, 0, 32'h0, 2, d);
    tests++;
    if (d !== 5 + VX) begin
      fails++;
      $display("FAIL restart_latency: done at %0d, need %0d", d, 5 + VX);
    end
    check_words("xor", 32'h00200093, 32'h00100113, 32'h0020C1B3, JAL);
    repeat (3) @(negedge clk);
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL done_held: done=%b hold=%b, need 1 0", done, cpu_hold);
    end
  endtask

  task automatic test_reset_mid_load();
    int d;
    int n = 0;
    ops = {8'd5, 8'd10};
    alu_op = 3'b111;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!(we === 1'b1 && addr === 32'd8) && n < 20);
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL midrst_reach: word 2 not presented, addr=%h", addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (we !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0 || addr !== 32'h0) begin
      fails++;
      $display("FAIL midrst_state: we=%b done=%b hold=%b busy=%b addr=%h, need 0 0 1 0 0",
               we, done, cpu_hold, busy, addr);
    end
    run_load(60, 32'hFFFF_FFFF, 0, 32'h0, -1, d);
    tests++;
    if (d !== 5 + VX) begin
      fails++;
      $display("FAIL midrst_latency: done at %0d, need %0d", d, 5 + VX);
    end
    check_words("slt", 32'h00A00093, 32'h00500113, 32'h0020A1B3, JAL);
  endtask

  task automatic test_readback_bad();
    int cyc = 0;
    int passes = 0;
    bad = 1'b1;
    ops = {8'd5, 8'd10};
    alu_op = 3'b000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (we === 1'b1 && addr === 32'h0) passes++;
    end while (busy === 1'b1 && cyc < 200);
`ifdef IMEM_READBACK_VERIFY_EN
    tests++;
    if (passes !== 3) begin
      fails++;
      $display("FAIL verify_passes: passes=%0d, need 3", passes);
    end
    tests++;
    if (verify_err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL verify_fail: verr=%b done=%b hold=%b busy=%b, need 1 0 1 0",
               verify_err, done, cpu_hold, busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (verify_err !== 1'b1 || busy !== 1'b0 || we !== 1'b0) begin
      fails++;
      $display("FAIL verify_sticky: verr=%b busy=%b we=%b, need 1 0 0", verify_err, busy, we);
    end
`else
    tests++;
    if (passes !== 1 || cyc !== 5 || done !== 1'b1 || verify_err !== 1'b0 || raddr !== 32'h0) begin
      fails++;
      $display("FAIL noverify: passes=%0d cyc=%0d done=%b verr=%b raddr=%h, need 1 5 1 0 0",
               passes, cyc, done, verify_err, raddr);
    end
`endif
    bad = 1'b0;
  endtask

  initial begin
    test_reset();
    test_auto_load();
    test_sub_stall();
    test_back_to_back();
    test_reset_mid_load();
    test_readback_bad();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name:
imem_boot_loader

Overview:
- Parametrised successor to the fixed two-operand instruction loader.
- Synthesises a short RV32I program into instruction memory from N operand bytes and a 3-bit ALU-op select, then releases the CPU.
- Adds a valid/ready write handshake, restart on demand, an auto-start option and a CPU hold output.
- Sits between board switches/constants and the pipelined CPU's imem write port in the FPGA top.

Parameters:
- N_OPS, 2, operand count, legal 1..4; program length is N_OPS+2 words.
- OP_W, 8, operand width in bits, legal 1..12; zero-extended into the addi immediate.
- BASE_ADDR, 32'h0, byte address of the first program word.
- AUTO_START, 1, when 1 a load begins automatically on the first cycle after reset deasserts.
- MAX_RETRY, 2, reload attempts after a verify mismatch (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to (re)load; ignored while busy.
- ops  in  N_OPS*OP_W  operand k at bits [k*OP_W +: OP_W]; latched on accepted start.
- alu_op  in  3  operation select; latched with ops.
- imem_ready  in  1  memory accepts the presented write this cycle.
- imem_we  out  1  write valid.
- imem_addr  out  32  byte address of the presented word.
- imem_wdata  out  32  instruction word.
- busy  out  1  load (or verify) in progress.
- done  out  1  program fully written; held until the next accepted start or rst.
- cpu_hold  out  1  drives the CPU reset; high unless done=1.
- imem_raddr  out  32  readback address (optional feature).
- imem_rdata  in  32  readback data, 1-cycle latency (optional feature).
- verify_err  out  1  sticky readback failure (optional feature).

Behaviour:
- Reset values: imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, cpu_hold=1, verify_err=0, imem_raddr=BASE_ADDR.
- FSM states IDLE, LOAD, VERIFY, DONE, FAIL; VERIFY and FAIL exist only with the optional feature.
- IDLE -> LOAD on start, or on the first post-reset cycle when AUTO_START=1; ops and alu_op are sampled that cycle.
- LOAD:
  - Word index i runs 0..N_OPS+1; imem_addr = BASE_ADDR + 4*i.
  - imem_we=1 throughout; a word is written when imem_we && imem_ready.
  - When imem_ready=0, addr, data and we are held stable; i advances only on acceptance.
  - Zero-wait throughput is one word per cycle.
- Program words:
  - i<N_OPS: addi x(i+1),x0,ops[i] = {zext12(ops[i]),5'd0,3'b000,rd=i+1,7'h13}.
  - i=N_OPS: R-type, rd=N_OPS+1, rs1=x1, rs2=x2 (x1 when N_OPS=1), opcode 7'h33.
  - alu_op map (funct7/funct3): 000 add 00/0, 001 sub 20/0, 010 and 00/7, 011 or 00/6, 100 xor 00/4, 101 sll 00/1, 110 srl 00/5, 111 slt 00/2.
  - i=N_OPS+1: jal x0,0 = 32'h0000006F.
- Completion and control:
  - After the last word is accepted: LOAD -> DONE on the next edge; imem_we=0, done=1, busy=0, cpu_hold=0.
  - start in DONE restarts: done=0 and cpu_hold=1 the next cycle, then LOAD from i=0.
  - start while busy is ignored; latched operands do not change.
  - rst at any time, including mid-LOAD, returns to IDLE with reset values in the next cycle; the partial program is abandoned.
- Latency, zero-wait: accepted start to done=1 is N_OPS+3 cycles.

Optional Feature:
- IMEM_READBACK_VERIFY_EN defined:
  - LOAD -> VERIFY: each word is read back via imem_raddr and compared with the regenerated word one cycle later.
  - All match -> DONE.
  - Mismatch -> LOAD again, up to MAX_RETRY reloads; after that -> FAIL: verify_err=1, done=0, cpu_hold=1, busy=0.
  - FAIL exits only on rst; start is ignored in FAIL.
  - Latency increases by N_OPS+3 cycles per pass.
- Undefined: the ports remain; imem_raddr=BASE_ADDR, verify_err=0, imem_rdata is ignored, and LOAD goes straight to DONE.

Decomposition:
- Package boot_pkg:
  - Opcode constants OPC_OPIMM=7'h13, OPC_OP=7'h33, JAL_SELF=32'h0000006F.
  - alu_op-to-funct7/funct3 table.
  - FSM state enum.
- Sub-module rv_instr_encoder (combinational): inputs word index, latched ops and alu_op; output the instruction word.
  - Shared by LOAD and by VERIFY compare.

Test Plan:
- N_OPS=2, ops={5,10}, alu_op=000, imem_ready=1, AUTO_START=1 -> writes 0x00A00093@0, 0x00500113@4, 0x002081B3@8, 0x0000006F@12; done=1 at cycle 5 after reset release; cpu_hold then falls.
- Same ops, alu_op=001 -> word 2 = 0x402081B3.
- imem_ready low for 3 cycles during word 1 -> addr=4 and data held stable; 4 writes total; done delayed by exactly 3 cycles.
- In DONE, start with ops={1,2}, alu_op=100 -> cpu_hold=1 the next cycle; word 0 = 0x00200093; word 2 = 0x0020C1B3; done re-asserts.
- rst pulsed while writing word 2 -> next cycle imem_we=0, done=0, cpu_hold=1; with AUTO_START=1, a reload restarts at address 0.
- With IMEM_READBACK_VERIFY_EN, imem_rdata at word 1 forced to 0 on every pass -> 3 load passes, then verify_err=1, done=0, cpu_hold=1.
